// File: rtl/serdes_word_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : serdes_word_scheduler
// Brief   : Word scheduler for the calibration oserdes: trigger words preempt
//           calibration bursts, null guard words follow every event.
//           Define CAL_PRBS_EN for PRBS7 calibration words (else AA/55 pattern).
// Rev     : 1.0
// ============================================================================
module serdes_word_scheduler #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] WORD_NULL     = 8'b11000000,
    parameter logic [WIDTH-1:0] WORD_TRG      = 8'b00111111,
    parameter logic [WIDTH-1:0] WORD_CAL      = 8'b10101010,
    parameter int               TRG_WORDS     = 1,
    parameter int               CAL_WORDS     = 64,
    parameter int               GAP_WORDS     = 2,
    parameter int               COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     trg_in,
    input  logic                     cal_req,
    output logic                     cal_ack,
    output logic                     cal_busy,
    output logic                     cal_done,
    output logic                     cal_aborted,
    output logic [WIDTH-1:0]         word_out,
    output logic [1:0]               state_out,
    output logic [COUNTER_WIDTH-1:0] trg_count,
    output logic [COUNTER_WIDTH-1:0] cal_count,
    output logic [COUNTER_WIDTH-1:0] trg_dropped_count
);

    localparam int MAX_TC    = (TRG_WORDS > CAL_WORDS) ? TRG_WORDS : CAL_WORDS;
    localparam int MAX_WORDS = (MAX_TC > GAP_WORDS) ? MAX_TC : GAP_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    localparam logic [CNT_W-1:0]         TRG_LOAD = CNT_W'(TRG_WORDS - 1);
    localparam logic [CNT_W-1:0]         CAL_LOAD = CNT_W'(CAL_WORDS - 1);
    localparam logic [CNT_W-1:0]         GAP_LOAD = CNT_W'(GAP_WORDS - 1);
    localparam logic [CNT_W-1:0]         WC_ONE   = 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TRG  = 2'b01,
        ST_CAL  = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trg_s_q;
    logic             trg_q;
    logic             pending_q;
    logic             pending_d;
    logic             trg_edge;
    logic             take_trg;
    logic             drop_trg;
    logic             cal_start;
    logic [WIDTH-1:0] cal_first_word;
    logic [WIDTH-1:0] cal_next_word;

    // A pending trigger is consumed only from IDLE or by preempting CAL.
    assign trg_edge  = trg_s_q & ~trg_q;
    assign take_trg  = pending_q & ((state_q == ST_IDLE) | (state_q == ST_CAL));
    assign pending_d = take_trg ? trg_edge : (pending_q | trg_edge);
    assign drop_trg  = trg_edge & pending_q & ~take_trg;
    assign cal_start = (state_q == ST_IDLE) & ~pending_q & cal_req;
    assign state_out = state_q;

`ifdef CAL_PRBS_EN
    logic [6:0]       lfsr_q;
    logic [WIDTH+6:0] prbs_first;
    logic [WIDTH+6:0] prbs_cont;

    // Returns {word, next_lfsr}: WIDTH output bits MSB first, x^7+x^6+1.
    function automatic logic [WIDTH+6:0] prbs_step(input logic [6:0] seed);
        logic [6:0]       r;
        logic [WIDTH-1:0] w;
        r = seed;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w[WIDTH-1-i] = r[6];
            r            = {r[5:0], r[6] ^ r[5]};
        end
        return {w, r};
    endfunction

    assign prbs_first     = prbs_step(7'h7f);
    assign prbs_cont      = prbs_step(lfsr_q);
    assign cal_first_word = prbs_first[WIDTH+6:7];
    assign cal_next_word  = prbs_cont[WIDTH+6:7];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 7'h7f;
        end else if (cal_start) begin
            lfsr_q <= prbs_first[6:0];
        end else if (state_q == ST_CAL) begin
            lfsr_q <= prbs_cont[6:0];
        end
    end
`else
    logic cal_odd_q;

    assign cal_first_word = WORD_CAL;
    assign cal_next_word  = cal_odd_q ? ~WORD_CAL : WORD_CAL;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cal_odd_q <= 1'b0;
        end else if (cal_start) begin
            cal_odd_q <= 1'b1;
        end else if (state_q == ST_CAL) begin
            cal_odd_q <= ~cal_odd_q;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            trg_s_q           <= 1'b0;
            trg_q             <= 1'b0;
            pending_q         <= 1'b0;
            word_out          <= WORD_NULL;
            cal_ack           <= 1'b0;
            cal_busy          <= 1'b0;
            cal_done          <= 1'b0;
            cal_aborted       <= 1'b0;
            trg_count         <= '0;
            cal_count         <= '0;
            trg_dropped_count <= '0;
        end else begin
            trg_s_q     <= trg_in;
            trg_q       <= trg_s_q;
            pending_q   <= pending_d;
            cal_ack     <= 1'b0;
            cal_done    <= 1'b0;
            cal_aborted <= 1'b0;
            if (drop_trg && !(&trg_dropped_count)) begin
                trg_dropped_count <= trg_dropped_count + CNT_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_q   <= ST_TRG;
                        cnt_q     <= TRG_LOAD;
                        word_out  <= WORD_TRG;
                        trg_count <= trg_count + CNT_ONE;
                    end else if (cal_req) begin
                        state_q  <= ST_CAL;
                        cnt_q    <= CAL_LOAD;
                        word_out <= cal_first_word;
                        cal_ack  <= 1'b1;
                        cal_busy <= 1'b1;
                    end else begin
                        word_out <= WORD_NULL;
                    end
                end
                ST_TRG: begin
                    if (cnt_q == '0) begin
                        word_out <= WORD_NULL;
                        if (GAP_WORDS > 0) begin
                            state_q <= ST_GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - WC_ONE;
                    end
                end
                ST_CAL: begin
                    if (pending_q) begin
                        // Preempt: the burst is abandoned, not resumed.
                        state_q     <= ST_TRG;
                        cnt_q       <= TRG_LOAD;
                        word_out    <= WORD_TRG;
                        trg_count   <= trg_count + CNT_ONE;
                        cal_done    <= 1'b1;
                        cal_aborted <= 1'b1;
                        cal_busy    <= 1'b0;
                    end else if (cnt_q == '0) begin
                        word_out  <= WORD_NULL;
                        cal_done  <= 1'b1;
                        cal_busy  <= 1'b0;
                        cal_count <= cal_count + CNT_ONE;
                        if (GAP_WORDS > 0) begin
                            state_q <= ST_GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q    <= cnt_q - WC_ONE;
                        word_out <= cal_next_word;
                    end
                end
                ST_GAP: begin
                    word_out <= WORD_NULL;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - WC_ONE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    word_out <= WORD_NULL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
